reg_cfg_master: RTL and testbench
=================================

REG_CFG_MASTER -- requirements
Module: reg_cfg_master

Interface
REQ-001 SHALL have parameter STATUS_RETRIES, default 3: total status-read attempts before a status error, legal range 1..15.
REQ-002 SHALL have parameter STATUS_MAGIC, default 8'hAA: expected status value at address 0x10.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle configuration request; ignored while busy=1.
REQ-006 SHALL have port cfg_mode, input, 2: target mode value.
REQ-007 SHALL have port cfg_kernel, input, 72: coefficients; coefficient k is at [8k+7:8k], k=0..8.
REQ-008 SHALL have port reg_write_en, output, 1: register write strobe to the pixel processor.
REQ-009 SHALL have port reg_addr, output, 5: register address.
REQ-010 SHALL have port reg_wdata, output, 8: write data.
REQ-011 SHALL have port reg_rdata, input, 8: read data, combinationally valid for the reg_addr driven in the same cycle.
REQ-012 SHALL have port busy, output, 1: high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-013 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port err_code, output, 2: 00 ok, 01 status timeout, 10 mode readback mismatch.

Function
REQ-015 SHALL drive all outputs from registers only.
REQ-016 SHALL capture cfg_mode and cfg_kernel on the edge at which start=1 is accepted in IDLE; later input changes SHALL NOT affect the sequence.
REQ-017 SHALL use the states IDLE, STAT, MSAFE, KERN, MFINAL, RDBK and FIN, with exactly one bus access per cycle.
REQ-018 SHALL have STAT drive reg_addr=0x10 with reg_write_en=0 and sample reg_rdata; on a match go to MSAFE, else retry; after STATUS_RETRIES failed attempts set err_code=01 and go to FIN.
REQ-019 SHALL have MSAFE write 0x00 to address 0x00, forcing bypass so the kernel is never partially applied.
REQ-020 SHALL have KERN perform 9 consecutive writes: address 0x04+k with coefficient k, for k=0..8 in ascending order.
REQ-021 SHALL have MFINAL write {6'b0, captured mode} to address 0x00.
REQ-022 SHALL have RDBK read address 0x00 and compare reg_rdata with {6'b0, captured mode}; a mismatch SHALL set err_code=10; then go to FIN.
REQ-023 SHALL have FIN assert done for exactly one cycle, then return to IDLE.
REQ-024 SHALL hold err_code from the FIN cycle until the next accepted start, which clears it to 00.
REQ-025 SHALL drive reg_write_en=1 only in MSAFE, KERN and MFINAL.
REQ-026 SHALL drive reg_wdata=0 on every non-write cycle.
REQ-027 SHALL drive reg_addr=0 in IDLE and FIN.
REQ-028 SHALL fix success latency: with start accepted at edge E0 and the first STAT attempt matching, STAT is cycle 1, MSAFE cycle 2, KERN cycles 3-11, MFINAL cycle 12, RDBK cycle 13, done cycle 14.
REQ-029 SHALL extend total latency by one cycle for each failed status attempt.
REQ-030 SHALL NOT start a back-to-back request: start in the FIN cycle is ignored; start in the first IDLE cycle after FIN is accepted.
REQ-031 SHALL, when the status check errors, issue no writes in that sequence.

Reset
REQ-032 SHALL, while rst=1, force IDLE with reg_write_en=0, reg_addr=0, reg_wdata=0, busy=0, done=0, err_code=00, retry counter=0 and captured config=0.
REQ-033 SHALL, on reset asserted mid-sequence, issue no further writes and leave no done pulse pending.
REQ-034 SHALL NOT accept start during a cycle in which rst=1.

Verification
REQ-035 SHALL pass: responder model, start with cfg_mode=10 and kernel 0,-1,0,-1,5,-1,0,-1,0 -> writes 0x00<-00, 0x04..0x0C <- 00,FF,00,FF,05,FF,00,FF,00, then 0x00<-02, done at cycle 14, err_code=00.
REQ-036 SHALL pass: status returns 0x00 twice then 0xAA -> two extra STAT cycles, done at cycle 16, err_code=00.
REQ-037 SHALL pass: status always 0x55 -> exactly 3 reads of 0x10, zero writes, done at cycle 4, err_code=01.
REQ-038 SHALL pass: responder ignores writes to 0x00 (returns 00), cfg_mode=01 -> full write sequence, then err_code=10 with done.
REQ-039 SHALL pass: rst=1 asserted at cycle 6 (inside KERN) -> no writes from the next cycle, all outputs zero; a new start completes normally.
REQ-040 SHALL pass: start held high for 20 cycles -> exactly one sequence runs, then a second is accepted in the IDLE cycle after FIN.

Source files
------------

// File: rtl/reg_cfg_master_if.sv
// Register bus between the configuration master and the pixel processor.
// The master drives the write strobe, address and write data. The slave
// returns read data combinationally for the address driven in the same cycle.
interface reg_cfg_master_if;
  logic       reg_write_en;
  logic [4:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;

  modport master (
    output reg_write_en,
    output reg_addr,
    output reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_write_en,
    input  reg_addr,
    input  reg_wdata,
    output reg_rdata
  );
endinterface

// File: rtl/reg_cfg_master.sv
// Configuration master for the pixel processor. One accepted start runs
// these steps, with one bus access per cycle:
//   - poll the status register until it returns the expected value
//   - force bypass mode
//   - load the nine kernel coefficients
//   - write the requested mode
//   - read the mode back to confirm it
// Every output comes straight from a register.
module reg_cfg_master #(
  parameter int          STATUS_RETRIES = 3,
  parameter logic [7:0]  STATUS_MAGIC   = 8'hAA
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              cfg_mode,
  input  logic [71:0]             cfg_kernel,
  reg_cfg_master_if.master        bus,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err_code
);

  typedef enum logic [2:0] {
    IDLE,
    STAT,
    MSAFE,
    KERN,
    MFINAL,
    RDBK,
    FIN
  } state_t;

  localparam logic [3:0] LAST_TRY    = 4'(STATUS_RETRIES - 1);
  localparam logic [3:0] LAST_COEF   = 4'd8;
  localparam logic [4:0] ADDR_MODE   = 5'h00;
  localparam logic [4:0] ADDR_KERN0  = 5'h04;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_STATUS  = 2'b01;
  localparam logic [1:0] ERR_MODE    = 2'b10;

  state_t      state_q;
  logic [3:0]  retry_q;
  logic [3:0]  kIdx_q;
  logic [1:0]  mode_q;
  logic [71:0] kernel_q;
  logic        writeEn_q;
  logic [4:0]  addr_q;
  logic [7:0]  wdata_q;
  logic        busy_q;
  logic        done_q;
  logic [1:0]  err_q;

  logic [3:0]  kIdx_d;
  logic [4:0]  kAddr_d;
  logic [7:0]  kData_d;

  // Address and data of the next coefficient write while walking the kernel.
  always_comb begin
    kIdx_d  = kIdx_q + 4'd1;
    kAddr_d = ADDR_KERN0 + {1'b0, kIdx_d};
    kData_d = 8'(kernel_q >> {kIdx_d, 3'b000});
  end

  // Sequencer. Each state loads the bus registers for the access that the next state performs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      retry_q   <= 4'd0;
      kIdx_q    <= 4'd0;
      mode_q    <= 2'd0;
      kernel_q  <= 72'd0;
      writeEn_q <= 1'b0;
      addr_q    <= 5'd0;
      wdata_q   <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= cfg_mode;
            kernel_q  <= cfg_kernel;
            err_q     <= ERR_OK;
            busy_q    <= 1'b1;
            retry_q   <= 4'd0;
            writeEn_q <= 1'b0;
            addr_q    <= ADDR_STATUS;
            wdata_q   <= 8'd0;
            state_q   <= STAT;
          end
        end
        STAT: begin
          if (bus.reg_rdata == STATUS_MAGIC) begin
            writeEn_q <= 1'b1;
            addr_q    <= ADDR_MODE;
            wdata_q   <= 8'd0;
            state_q   <= MSAFE;
          end else if (retry_q == LAST_TRY) begin
            err_q     <= ERR_STATUS;
            done_q    <= 1'b1;
            addr_q    <= 5'd0;
            state_q   <= FIN;
          end else begin
            retry_q   <= retry_q + 4'd1;
          end
        end
        MSAFE: begin
          kIdx_q    <= 4'd0;
          addr_q    <= ADDR_KERN0;
          wdata_q   <= kernel_q[7:0];
          state_q   <= KERN;
        end
        KERN: begin
          if (kIdx_q == LAST_COEF) begin
            addr_q  <= ADDR_MODE;
            wdata_q <= {6'b0, mode_q};
            state_q <= MFINAL;
          end else begin
            kIdx_q  <= kIdx_d;
            addr_q  <= kAddr_d;
            wdata_q <= kData_d;
          end
        end
        MFINAL: begin
          writeEn_q <= 1'b0;
          addr_q    <= ADDR_MODE;
          wdata_q   <= 8'd0;
          state_q   <= RDBK;
        end
        RDBK: begin
          if (bus.reg_rdata != {6'b0, mode_q}) begin
            err_q <= ERR_MODE;
          end
          done_q  <= 1'b1;
          addr_q  <= 5'd0;
          state_q <= FIN;
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          writeEn_q <= 1'b0;
          addr_q    <= 5'd0;
          wdata_q   <= 8'd0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.reg_write_en = writeEn_q;
  assign bus.reg_addr     = addr_q;
  assign bus.reg_wdata    = wdata_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err_code         = err_q;

endmodule

// File: tb/tb_reg_cfg_master.sv
// Directed bench for reg_cfg_master with a small register-file responder.
// Table vectors cover the main sequences. Hand-written sequences cover
// reset in the middle of a sequence and a start held high.
module tb_reg_cfg_master;

  typedef struct {
    logic [1:0]  mode;
    logic [71:0] kernel;
    int          failReads;
    logic [7:0]  failVal;
    bit          ignoreMode0;
    int          expDone;
    logic [1:0]  expErr;
    int          expWrites;
    int          expStat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [71:0] cfg_kernel;
  logic        busy;
  logic        done;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  int         failReads;
  logic [7:0] failVal;
  bit         ignoreMode0;
  int         statBase;

  int         statReads = 0;
  int         wrCount   = 0;
  int         wdataViol = 0;
  logic [7:0] mode0Reg  = 8'h00;
  logic [4:0] wrAddr [0:255];
  logic [7:0] wrData [0:255];

  vec_t vecs [7];

  reg_cfg_master_if bus ();

  reg_cfg_master #(
    .STATUS_RETRIES (3),
    .STATUS_MAGIC   (8'hAA)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_mode   (cfg_mode),
    .cfg_kernel (cfg_kernel),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Responder read path. Status reads fail a set number of times before
  // returning the magic value. Mode reads can be made to ignore writes.
  always_comb begin
    bus.reg_rdata = 8'h00;
    if (bus.reg_addr == 5'h10) begin
      bus.reg_rdata = ((statReads - statBase) < failReads) ? failVal : 8'hAA;
    end else if (bus.reg_addr == 5'h00) begin
      bus.reg_rdata = ignoreMode0 ? 8'h00 : mode0Reg;
    end
  end

  // Responder write path. Logs every write and counts every status read.
  always @(posedge clk) begin
    if (bus.reg_write_en) begin
      wrAddr[wrCount[7:0]] <= bus.reg_addr;
      wrData[wrCount[7:0]] <= bus.reg_wdata;
      wrCount <= wrCount + 1;
      if (bus.reg_addr == 5'h00) mode0Reg <= bus.reg_wdata;
    end
    if (!bus.reg_write_en && bus.reg_addr == 5'h10) statReads <= statReads + 1;
  end

  // Write data must be zero on every cycle that is not a write.
  always @(negedge clk) begin
    if (!bus.reg_write_en && bus.reg_wdata != 8'h00) wdataViol <= wdataViol + 1;
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Returns the i-th write of a sequence that succeeds, as {addr, data}.
  function automatic logic [12:0] expWrite(input vec_t v, input int i);
    if (i == 0) return {5'h00, 8'h00};
    if (i <= 9) return {5'(4 + i - 1), v.kernel[8*(i-1) +: 8]};
    return {5'h00, 6'b0, v.mode};
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int wrBase;
    int doneAt;
    int nWr;
    bit busyOk;
    @(posedge clk); #1;
    failReads   = v.failReads;
    failVal     = v.failVal;
    ignoreMode0 = v.ignoreMode0;
    statBase    = statReads;
    wrBase      = wrCount;
    cfg_mode    = v.mode;
    cfg_kernel  = v.kernel;
    start       = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    cfg_mode   = ~v.mode;
    cfg_kernel = ~v.kernel;
    checkOutput($sformatf("%s err cleared", tag), err_code, 2'b00);
    doneAt = 0;
    busyOk = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      if (n > 1) begin
        @(posedge clk); #1;
      end
      if (!busy) busyOk = 1'b0;
      if (done) begin
        doneAt = n;
        break;
      end
    end
    checkOutput($sformatf("%s done cycle", tag), doneAt, v.expDone);
    checkOutput($sformatf("%s busy window", tag), busyOk, 1'b1);
    checkOutput($sformatf("%s err_code", tag), err_code, v.expErr);
    @(posedge clk); #1;
    checkOutput($sformatf("%s idle after done", tag), {busy, done, err_code}, {1'b0, 1'b0, v.expErr});
    nWr = wrCount - wrBase;
    checkOutput($sformatf("%s write count", tag), nWr, v.expWrites);
    checkOutput($sformatf("%s status reads", tag), statReads - statBase, v.expStat);
    for (int i = 0; i < v.expWrites && i < nWr; i++) begin
      checkOutput($sformatf("%s write %0d", tag, i),
                  {wrAddr[8'(wrBase + i)], wrData[8'(wrBase + i)]}, expWrite(v, i));
    end
  endtask

  initial begin
    int wrBase;
    int dones;
    int d1;
    int d2;
    bit idleGap;

    vecs[0] = '{2'd2, 72'h00FF00FF05FF00FF00,   0, 8'h00, 1'b0, 14, 2'b00, 11, 1};
    vecs[1] = '{2'd1, 72'h090807060504030201,   2, 8'h00, 1'b0, 16, 2'b00, 11, 3};
    vecs[2] = '{2'd3, 72'h112233445566778899, 255, 8'h55, 1'b0,  4, 2'b01,  0, 3};
    vecs[3] = '{2'd1, 72'h807060504030201008,   0, 8'h00, 1'b1, 14, 2'b10, 11, 1};
    vecs[4] = '{2'd3, 72'hFEDCBA9876543210AB,   0, 8'h00, 1'b0, 14, 2'b00, 11, 1};
    vecs[5] = '{2'd0, 72'h0102040810204080FF,   0, 8'h00, 1'b1, 14, 2'b00, 11, 1};
    vecs[6] = '{2'd2, 72'h5A5A5A5A5A5A5A5A5A,   1, 8'hAB, 1'b0, 15, 2'b00, 11, 2};

    rst         = 1'b1;
    start       = 1'b0;
    cfg_mode    = 2'd0;
    cfg_kernel  = 72'd0;
    failReads   = 0;
    failVal     = 8'h00;
    ignoreMode0 = 1'b0;
    statBase    = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset outputs",
                {bus.reg_write_en, bus.reg_addr, bus.reg_wdata, busy, done, err_code}, 18'd0);
    start = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("start during reset ignored", busy, 1'b0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset inside KERN: five writes (MSAFE plus k=0..3) are logged, then nothing.
    @(posedge clk); #1;
    failReads   = 0;
    ignoreMode0 = 1'b0;
    statBase    = statReads;
    wrBase      = wrCount;
    cfg_mode    = 2'd3;
    cfg_kernel  = 72'h0A0B0C0D0E0F101112;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid reset outputs",
                {bus.reg_write_en, bus.reg_addr, bus.reg_wdata, busy, done, err_code}, 18'd0);
    @(posedge clk); #1;
    rst   = 1'b0;
    dones = 0;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    checkOutput("mid reset no done", dones, 0);
    checkOutput("mid reset writes", wrCount - wrBase, 5);
    applyStimulus(vecs[0], "post-reset");

    // Start held high for 20 cycles: two sequences, second one accepted in the IDLE cycle after FIN.
    @(posedge clk); #1;
    failReads   = 0;
    ignoreMode0 = 1'b0;
    statBase    = statReads;
    cfg_mode    = 2'd2;
    cfg_kernel  = 72'h00FF00FF05FF00FF00;
    start       = 1'b1;
    dones   = 0;
    d1      = 0;
    d2      = 0;
    idleGap = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 20) start = 1'b0;
      if (n == 15 && !busy) idleGap = 1'b1;
      if (done) begin
        dones++;
        if (dones == 1) d1 = n;
        if (dones == 2) d2 = n;
      end
    end
    checkOutput("held start done count", dones, 2);
    checkOutput("held start first done", d1, 14);
    checkOutput("held start idle gap", idleGap, 1'b1);
    checkOutput("held start second done", d2, 29);

    checkOutput("wdata idle zero", wdataViol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
